// File: rtl/shift_register_rx.sv
// -----------------------------------------------------------------------------
// shift_register_rx
//
// Serial-to-parallel receiver for the 32-bit parallel-load serial transmitter.
// The transmitter gates its data line with its serial clock (LSB first) and
// raises a busy/frame signal for the duration of each word. All three lines
// are asynchronous to CLK, so each passes through an equal-depth synchroniser
// to keep their relative timing. A bit is taken on each synchronised falling
// edge of SCLK, using the data value captured while SCLK was high. After WIDTH
// bits the word is presented on DOUT with a valid/acknowledge handshake.
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      asynchronous, active-high reset
//   SIN        gated serial data (meaningful only while SCLK is high)
//   SCLK       transmitter serial clock
//   RX_EN      frame enable (transmitter busy)
//   RD_ACK     consumer acknowledge, clears DATA_VALID
//   DOUT       last complete received word
//   DATA_VALID DOUT holds an unread word
//   RX_DONE    one-cycle pulse when a word completes
//   RX_BUSY    high while a frame is being received
//   RX_ERR     one-cycle pulse when a frame is truncated
//   OVERRUN    sticky: a word completed while the previous one was unread
// -----------------------------------------------------------------------------
module shift_register_rx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter bit LSB_FIRST   = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SIN,
    input  logic             SCLK,
    input  logic             RX_EN,
    input  logic             RD_ACK,
    output logic [WIDTH-1:0] DOUT,
    output logic             DATA_VALID,
    output logic             RX_DONE,
    output logic             RX_BUSY,
    output logic             RX_ERR,
    output logic             OVERRUN
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HOLD
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] sin_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic [SYNC_STAGES-1:0] settle;

    logic             sin_s;
    logic             sclk_s;
    logic             en_s;
    logic             sclk_prev;
    logic             en_prev;
    logic             sin_hold;
    logic             armed;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    bit_cnt;

    logic bit_event;
    logic en_rise;
    logic en_fall;
    logic word_full;

    assign sin_s  = sin_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign en_s   = en_sync[SYNC_STAGES-1];

    // A frame may only start once the enable has been seen low with a fully
    // populated synchroniser. This stops an enable that was already high when
    // RESET released from looking like a fresh frame start.
    assign bit_event = sclk_prev & ~sclk_s;
    assign en_rise   = en_s & ~en_prev & armed;
    assign en_fall   = ~en_s & en_prev;
    assign word_full = (bit_cnt == CW'(WIDTH));

    // Shift direction decides which end of DOUT the first received bit lands in.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign shifted = {sin_hold, shreg[WIDTH-1:1]};
        end else begin : g_msb_first
            assign shifted = {shreg[WIDTH-2:0], sin_hold};
        end
    endgenerate

    assign RX_BUSY = (state == RECV);

    // Input synchronisers, edge-detect history and the high-phase data capture.
    // settle fills with ones after reset so we know when the chains carry real
    // input values rather than their reset zeros.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sin_sync  <= '0;
            sclk_sync <= '0;
            en_sync   <= '0;
            settle    <= '0;
            sclk_prev <= 1'b0;
            en_prev   <= 1'b0;
            sin_hold  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sin_sync  <= {sin_sync[SYNC_STAGES-2:0], SIN};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            en_sync   <= {en_sync[SYNC_STAGES-2:0], RX_EN};
            settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s;
            en_prev   <= en_s;
            if (sclk_s) begin
                sin_hold <= sin_s;
            end
            if (settle[SYNC_STAGES-1] && !en_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Frame FSM with the shift register, bit counter and all handshake outputs.
    // Completion takes priority over a coincident enable drop, and a completing
    // word always wins over a coincident acknowledge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            DOUT       <= '0;
            DATA_VALID <= 1'b0;
            RX_DONE    <= 1'b0;
            RX_ERR     <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            RX_DONE <= 1'b0;
            RX_ERR  <= 1'b0;
            if (RD_ACK) begin
                DATA_VALID <= 1'b0;
            end
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (en_rise) begin
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (word_full) begin
                        DOUT       <= shreg;
                        DATA_VALID <= 1'b1;
                        RX_DONE    <= 1'b1;
                        if (DATA_VALID && !RD_ACK) begin
                            OVERRUN <= 1'b1;
                        end
                        state <= HOLD;
                    end else if (en_fall) begin
                        RX_ERR  <= 1'b1;
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else if (bit_event) begin
                        shreg   <= shifted;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (en_fall) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_register_rx.sv
// -----------------------------------------------------------------------------
// tb_shift_register_rx
//
// Drives transmitter-style frames (gated data, serial clock, frame enable) into
// shift_register_rx and compares its outputs against a word-level model of the
// receiver's observable behaviour: completed words, valid/overrun handshake,
// pulse counts and completion latency.
// -----------------------------------------------------------------------------
module tb_shift_register_rx;

    localparam int WIDTH       = 32;
    localparam int SYNC_STAGES = 2;
    localparam int LATENCY     = SYNC_STAGES + 2;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             SIN;
    logic             SCLK;
    logic             RX_EN;
    logic             RD_ACK;
    logic [WIDTH-1:0] DOUT;
    logic             DATA_VALID;
    logic             RX_DONE;
    logic             RX_BUSY;
    logic             RX_ERR;
    logic             OVERRUN;

    int n_checks    = 0;
    int n_fail      = 0;
    int done_cycles = 0;
    int err_cycles  = 0;
    int busy_cycles = 0;
    int hi_cyc      = 4;
    int lo_cyc      = 4;
    int last_latency;

    // Word-level reference state
    logic [WIDTH-1:0] m_dout;
    logic             m_valid;
    logic             m_over;

    always #5 CLK = ~CLK;

    shift_register_rx #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .LSB_FIRST   (1'b1)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SIN        (SIN),
        .SCLK       (SCLK),
        .RX_EN      (RX_EN),
        .RD_ACK     (RD_ACK),
        .DOUT       (DOUT),
        .DATA_VALID (DATA_VALID),
        .RX_DONE    (RX_DONE),
        .RX_BUSY    (RX_BUSY),
        .RX_ERR     (RX_ERR),
        .OVERRUN    (OVERRUN)
    );

    // Count pulse/level cycles away from the active edge
    always @(negedge CLK) begin
        if (!RESET) begin
            if (RX_DONE === 1'b1) done_cycles++;
            if (RX_ERR === 1'b1)  err_cycles++;
            if (RX_BUSY === 1'b1) busy_cycles++;
        end
    end

    // Hard stop in case a wait never ends
    initial begin
        #2ms;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string tag, input logic [WIDTH-1:0] obs,
                                input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 3 time units after the last one
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #3;
    endtask

    // One serial bit; on the last bit of a word also measure RX_DONE latency
    task automatic send_bit(input logic b, input bit last);
        SCLK = 1'b1;
        SIN  = b;
        wait_cycles(hi_cyc);
        SCLK = 1'b0;
        SIN  = 1'b0;
        if (last) begin
            last_latency = -1;
            for (int k = 1; k <= LATENCY + 4; k++) begin
                @(posedge CLK);
                #1;
                if (RX_DONE === 1'b1 && last_latency < 0) last_latency = k;
                #2;
            end
        end else begin
            wait_cycles(lo_cyc);
        end
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] word, input int nbits,
                              input bit trailing);
        RX_EN = 1'b1;
        wait_cycles(3);
        for (int i = 0; i < nbits; i++) begin
            send_bit(word[i], i == WIDTH - 1);
        end
        if (trailing) send_bit(1'b1, 1'b0);
        RX_EN = 1'b0;
        wait_cycles(6);
    endtask

    task automatic pulse_ack();
        RD_ACK = 1'b1;
        wait_cycles(1);
        RD_ACK  = 1'b0;
        m_valid = 1'b0;
    endtask

    // Send one frame, update the model and compare all observable outputs
    task automatic apply_stimulus(input logic [WIDTH-1:0] word, input int nbits,
                                  input bit trailing, input string tag);
        int  d0, e0, b0;
        bit  full;
        d0   = done_cycles;
        e0   = err_cycles;
        b0   = busy_cycles;
        full = (nbits == WIDTH);
        send_frame(word, nbits, trailing);
        if (full) begin
            if (m_valid) m_over = 1'b1;
            m_dout  = word;
            m_valid = 1'b1;
        end
        check_output($sformatf("%s dout", tag), DOUT, m_dout);
        check_output($sformatf("%s data_valid", tag), WIDTH'(DATA_VALID), WIDTH'(m_valid));
        check_output($sformatf("%s overrun", tag), WIDTH'(OVERRUN), WIDTH'(m_over));
        check_output($sformatf("%s done cycles", tag), 32'(done_cycles - d0), full ? 32'd1 : 32'd0);
        check_output($sformatf("%s err cycles", tag), 32'(err_cycles - e0), full ? 32'd0 : 32'd1);
        check_output($sformatf("%s busy seen", tag), WIDTH'(busy_cycles > b0), WIDTH'(1));
        check_output($sformatf("%s busy after", tag), WIDTH'(RX_BUSY), WIDTH'(0));
        if (full) begin
            check_output($sformatf("%s latency", tag), 32'(last_latency), 32'(LATENCY));
        end
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        int d0, e0, b0, nb;

        RESET  = 1'b1;
        SIN    = 1'b0;
        SCLK   = 1'b0;
        RX_EN  = 1'b0;
        RD_ACK = 1'b0;
        m_dout  = '0;
        m_valid = 1'b0;
        m_over  = 1'b0;

        // Reset values
        wait_cycles(3);
        check_output("reset dout", DOUT, '0);
        check_output("reset data_valid", WIDTH'(DATA_VALID), WIDTH'(0));
        check_output("reset rx_done", WIDTH'(RX_DONE), WIDTH'(0));
        check_output("reset rx_busy", WIDTH'(RX_BUSY), WIDTH'(0));
        check_output("reset rx_err", WIDTH'(RX_ERR), WIDTH'(0));
        check_output("reset overrun", WIDTH'(OVERRUN), WIDTH'(0));
        RESET = 1'b0;
        wait_cycles(5);

        // 1: single frame at 8:1
        apply_stimulus(32'hA5C3_0F1E, WIDTH, 1'b0, "t1");

        // 2: back-to-back frames with acknowledge between
        pulse_ack();
        apply_stimulus(32'h0000_0001, WIDTH, 1'b0, "t2a");
        pulse_ack();
        apply_stimulus(32'h8000_0000, WIDTH, 1'b0, "t2b");

        // 3: overrun, sticky across a later acknowledge
        pulse_ack();
        apply_stimulus(32'h1234_5678, WIDTH, 1'b0, "t3a");
        apply_stimulus(32'hDEAD_BEEF, WIDTH, 1'b0, "t3b");
        pulse_ack();
        check_output("t3 valid after ack", WIDTH'(DATA_VALID), WIDTH'(0));
        check_output("t3 overrun after ack", WIDTH'(OVERRUN), WIDTH'(1));

        // 4: truncated frame after a good word
        apply_stimulus(32'h0000_0001, WIDTH, 1'b0, "t4a");
        apply_stimulus(32'hFFFF_FFFF, 17, 1'b0, "t4b");

        // 5: trailing clock edge absorbed in HOLD, then a normal frame
        apply_stimulus(32'h3C3C_A55A, WIDTH, 1'b1, "t5a");
        apply_stimulus(32'h0F0F_0F0F, WIDTH, 1'b0, "t5b");

        // 6: reset in the middle of a frame
        w = 32'h7777_1234;
        RX_EN = 1'b1;
        wait_cycles(3);
        for (int i = 0; i < 10; i++) send_bit(w[i], 1'b0);
        RESET = 1'b1;
        wait_cycles(1);
        check_output("t6 reset dout", DOUT, '0);
        check_output("t6 reset data_valid", WIDTH'(DATA_VALID), WIDTH'(0));
        check_output("t6 reset rx_busy", WIDTH'(RX_BUSY), WIDTH'(0));
        check_output("t6 reset overrun", WIDTH'(OVERRUN), WIDTH'(0));
        check_output("t6 reset rx_done", WIDTH'(RX_DONE), WIDTH'(0));
        check_output("t6 reset rx_err", WIDTH'(RX_ERR), WIDTH'(0));
        wait_cycles(1);
        RESET   = 1'b0;
        m_dout  = '0;
        m_valid = 1'b0;
        m_over  = 1'b0;
        d0 = done_cycles;
        e0 = err_cycles;
        b0 = busy_cycles;
        for (int i = 10; i < WIDTH; i++) send_bit(w[i], 1'b0);
        RX_EN = 1'b0;
        wait_cycles(6);
        check_output("t6 tail done", 32'(done_cycles - d0), 32'd0);
        check_output("t6 tail err", 32'(err_cycles - e0), 32'd0);
        check_output("t6 tail busy", 32'(busy_cycles - b0), 32'd0);
        check_output("t6 tail dout", DOUT, '0);
        apply_stimulus(32'hCAFE_F00D, WIDTH, 1'b0, "t6");

        // Randomised frames, clock phases, acknowledges and truncations
        for (int r = 0; r < 10; r++) begin
            hi_cyc = $urandom_range(2, 5);
            lo_cyc = $urandom_range(2, 5);
            w      = $urandom;
            if ($urandom_range(0, 1) == 1) pulse_ack();
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, WIDTH - 1) : WIDTH;
            apply_stimulus(w, nb, $urandom_range(0, 1) == 1, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_register_rx.md
Name: shift_register_rx

Overview:
Serial-to-parallel receiver, the far end of the team's 32-bit parallel-load serial transmitter. It takes the gated serial line (data ANDed with the serial clock, LSB first), the serial clock and the transmitter's busy/frame signal. It synchronises all three into the CLK domain, shifts in WIDTH bits and presents the word on a parallel output with a valid/acknowledge handshake. It sits on the receiving board/block, ahead of the consumer register file.

Parameters:
WIDTH, 32, bits per frame; also the length of the shift register.
SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2).
LSB_FIRST, 1, 1 = first received bit goes to DOUT[0]; 0 = first received bit goes to DOUT[WIDTH-1].

Ports:
CLK  input  1  system clock; all logic is on its rising edge.
RESET  input  1  asynchronous, active-high reset.
SIN  input  1  serial data, gated (valid only while SCLK is high); asynchronous to CLK.
SCLK  input  1  transmitter serial clock; asynchronous to CLK.
RX_EN  input  1  frame enable from the transmitter's busy output; asynchronous to CLK.
RD_ACK  input  1  consumer acknowledge; clears DATA_VALID.
DOUT  output  WIDTH  last complete received word.
DATA_VALID  output  1  DOUT holds an unread word.
RX_DONE  output  1  one-CLK pulse when a word completes.
RX_BUSY  output  1  high while the state is RECV.
RX_ERR  output  1  one-CLK pulse when a frame is truncated.
OVERRUN  output  1  sticky flag: a word completed while DATA_VALID was still set.

Behaviour:
- Reset and clocking: RESET is asynchronous, active-high; the clock is CLK.
- Reset values: DOUT=0, DATA_VALID=0, RX_DONE=0, RX_BUSY=0, RX_ERR=0, OVERRUN=0, shift register=0, bit counter=0, state=IDLE, all synchroniser flops=0.
- Synchronisers: SIN, SCLK and RX_EN each pass through a SYNC_STAGES flop chain, giving SIN_s, SCLK_s and EN_s. All three chains have equal depth so their relative alignment is preserved.
- Sample rule:
  - sin_hold captures SIN_s on every CLK cycle in which SCLK_s=1.
  - A bit event is a detected falling edge of SCLK_s (previous value 1, current value 0).
  - The bit value at a bit event is sin_hold, i.e. SIN as seen during the high phase.
- Clock ratio: CLK must run at least 4x the SCLK frequency, and the SCLK high phase must be at least 2 CLK periods.
- FSM states: IDLE, RECV, HOLD.
- IDLE:
  - Bit counter is held at 0.
  - On the rising edge of EN_s, go to RECV.
  - Bit events in IDLE are ignored.
- RECV:
  - Each bit event shifts the bit in and increments the counter.
  - With LSB_FIRST=1, the register shifts right and the new bit enters at the MSB, so the first bit ends in bit 0.
  - When the event that makes the counter reach WIDTH occurs, the next CLK cycle does all of the following, then the FSM goes to HOLD:
    - DOUT is loaded with the full word.
    - DATA_VALID is set to 1.
    - RX_DONE is high for exactly 1 cycle.
    - If DATA_VALID was already 1 and RD_ACK is not asserted in that cycle, OVERRUN is set; the new word still overwrites DOUT.
  - If EN_s falls with counter < WIDTH: RX_ERR pulses for 1 cycle, DOUT and DATA_VALID are unchanged, the counter clears, and the FSM goes to IDLE.
- HOLD:
  - Further bit events are ignored; this absorbs the transmitter's trailing clock edge.
  - When EN_s falls, go to IDLE. RX_ERR is not raised.
- RD_ACK:
  - Clears DATA_VALID on the next edge.
  - If RD_ACK coincides with a word completing, the new word wins: DATA_VALID stays 1 and OVERRUN is not set.
  - RD_ACK has no effect on OVERRUN.
- OVERRUN is cleared only by RESET.
- The counter is log2(WIDTH)+1 bits wide and never wraps; reaching WIDTH always exits RECV.
- RX_BUSY = (state==RECV).
- Latency: the 32nd SCLK falling edge reaches RX_DONE after SYNC_STAGES+2 CLK cycles.
- RESET asserted mid-frame aborts immediately to the reset values. The first frame after deassertion is accepted only after a fresh rising edge of EN_s.

Test Plan:
1. RESET, then frame 0xA5C3_0F1E sent LSB first, CLK:SCLK = 8:1 -> DOUT=0xA5C30F1E, RX_DONE a single 1-cycle pulse, DATA_VALID=1, OVERRUN=0, RX_BUSY low after the frame.
2. Two back-to-back frames 0x0000_0001 then 0x8000_0000, RD_ACK pulsed between them -> two RX_DONE pulses, final DOUT=0x80000000, OVERRUN=0.
3. Two frames 0x1234_5678 and 0xDEAD_BEEF with no RD_ACK -> DOUT=0xDEADBEEF, OVERRUN=1 and stays set after a later RD_ACK; DATA_VALID=0 after that RD_ACK.
4. RX_EN dropped after 17 bits of 0xFFFF_FFFF, following an earlier good word 0x1 -> one RX_ERR pulse, DOUT stays 0x00000001, no RX_DONE, FSM returns to IDLE.
5. Transmitter-style trailing 33rd SCLK edge while RX_EN is still high -> ignored in HOLD; the next frame 0x0F0F_0F0F is received correctly.
6. RESET pulsed at bit 10 of a frame -> all outputs are 0; the remaining bits of that frame are ignored until the next rising edge of RX_EN, and the following frame 0xCAFE_F00D is received intact.
